out_stream_ctrl: RTL and testbench
==================================

OUT_STREAM_CTRL -- requirements
Module: out_stream_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 256, pixels per row.
REQ-002 SHALL have parameter IMG_H, default 256, rows per frame.
REQ-003 SHALL have parameter DW, default 8, bits per channel.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on posedge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port go  in  1  request to start a frame.
REQ-007 SHALL have ports up_data0/1/2  in  DW each  upstream pixel, three channels.
REQ-008 SHALL have ports up_valid  in  1 and up_ready  out  1  upstream handshake.
REQ-009 SHALL have ports dn_data0/1/2  out  DW each  downstream pixel.
REQ-010 SHALL have ports dn_valid  out  1 and dn_ready  in  1  downstream handshake.
REQ-011 SHALL have port start_out  out  1  one-cycle frame-start pulse to the sink.
REQ-012 SHALL have port stop_out  out  1  level, frame complete.
REQ-013 SHALL have ports col  out  clog2(IMG_W) and row  out  clog2(IMG_H)  position of the current dn beat.
REQ-014 SHALL have port busy  out  1  high in START, RUN and DRAIN.

Function
REQ-015 SHALL implement FSM states IDLE, START, RUN, DRAIN and DONE.
REQ-016 IDLE/DONE + go SHALL move to START; START SHALL last exactly 1 cycle with start_out=1, then move to RUN.
REQ-017 go in START/RUN/DRAIN SHALL be ignored.
REQ-018 SHALL include a 2-entry FIFO skid buffer holding all three channels; up_ready = (state==RUN) && fill<2; dn_valid = fill>0.
REQ-019 SHALL accept an upstream beat on up_valid&up_ready; it SHALL appear on dn_* no earlier than the next cycle (1-cycle minimum latency).
REQ-020 SHALL, on a simultaneous push and pop, leave fill unchanged and preserve order; data SHALL never be dropped or duplicated.
REQ-021 SHALL count input beats; after IMG_W*IMG_H accepts it SHALL move to DRAIN, and up_ready SHALL be 0 in DRAIN.
REQ-022 SHALL advance col on dn_valid&dn_ready; col SHALL wrap from IMG_W-1 to 0 and row SHALL then increment.
REQ-023 SHALL move from DRAIN to DONE in the cycle after the final beat (row=IMG_H-1, col=IMG_W-1) is popped.
REQ-024 SHALL hold stop_out=1 throughout DONE; stop_out SHALL clear when START is entered.
REQ-025 SHALL clear col, row and the input counter on entry to START.
REQ-026 dn_data SHALL be stable while dn_valid=1 and dn_ready=0.

Reset
REQ-027 reset SHALL force IDLE, fill=0, counters=0, start_out=0, stop_out=0, dn_valid=0, up_ready=0 and busy=0.
REQ-028 reset mid-frame SHALL discard buffered data; the next frame SHALL require a new go.

Configuration
REQ-029 With OUT_STREAM_CTRL_EOL_EN defined, the block SHALL add outputs dn_eol (1) and dn_eof (1), carried with each beat: eol=1 when col=IMG_W-1, eof=1 on the final frame beat.
REQ-030 Without OUT_STREAM_CTRL_EOL_EN, the dn_eol/dn_eof ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, DW default and the IMG_W/IMG_H defaults.
REQ-032 The skid buffer SHALL be a sub-module osc_skid_fifo (depth 2, width 3*DW, plus 2 bits when the macro is defined).

Verification
REQ-033 IMG_W=4, IMG_H=2, dn_ready=1, up_valid=1, go pulse -> start_out high 1 cycle, 8 beats out in order, stop_out=1 after beat 8.
REQ-034 Random dn_ready stalls (50%, 1-32 cycles) over a 256x256 frame -> 65536 beats, data matches upstream sequence, no drop or duplicate.
REQ-035 dn_ready=0 with upstream valid -> up_ready falls after 2 accepts, dn_data held stable.
REQ-036 reset asserted at beat 3 of an IMG_W=4 frame -> all outputs reach reset values next cycle; a new go restarts with col=0, row=0.
REQ-037 go asserted during RUN -> no effect; go in DONE -> second frame runs and stop_out clears in START.
REQ-038 Macro defined, IMG_W=4, IMG_H=2 -> dn_eol on beats 4 and 8, dn_eof on beat 8 only.

Source files
------------

// File: rtl/out_stream_ctrl_pkg.sv
// rtl/out_stream_ctrl_pkg.sv - shared state enum and default geometry for out_stream_ctrl
package out_stream_ctrl_pkg;

  localparam int DEF_IMG_W = 256;
  localparam int DEF_IMG_H = 256;
  localparam int DEF_DW    = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } osc_state_t;

endpackage

// File: rtl/osc_skid_fifo.sv
// rtl/osc_skid_fifo.sv - two-entry skid FIFO between the upstream and downstream handshakes
module osc_skid_fifo #(
  parameter int W = 24
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_s_tvalid,
  input  logic [W-1:0] i_s_tdata,
  output logic         o_s_tready,
  output logic         o_m_tvalid,
  output logic [W-1:0] o_m_tdata,
  input  logic         i_m_tready
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_fill;
  logic         w_push;
  logic         w_pop;

  assign o_s_tready = (r_fill != 2'd2);
  assign o_m_tvalid = (r_fill != 2'd0);
  assign o_m_tdata  = r_mem[r_rd_ptr];
  assign w_push     = i_s_tvalid && o_s_tready;
  assign w_pop      = o_m_tvalid && i_m_tready;

  // Data storage; the head entry is never rewritten while it is occupied.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_s_tdata;
    end
  end

  // Pointer and occupancy bookkeeping; push+pop together keeps fill unchanged.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_fill   <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_push && !w_pop) begin
        r_fill <= r_fill + 2'd1;
      end else if (!w_push && w_pop) begin
        r_fill <= r_fill - 2'd1;
      end
    end
  end

endmodule

// File: rtl/out_stream_ctrl.sv
// rtl/out_stream_ctrl.sv - frame-sequenced output stream controller (option: OUT_STREAM_CTRL_EOL_EN adds dn_eol/dn_eof)
module out_stream_ctrl
  import out_stream_ctrl_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int DW    = DEF_DW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  input  logic [DW-1:0]            up_data0,
  input  logic [DW-1:0]            up_data1,
  input  logic [DW-1:0]            up_data2,
  input  logic                     up_valid,
  output logic                     up_ready,
  output logic [DW-1:0]            dn_data0,
  output logic [DW-1:0]            dn_data1,
  output logic [DW-1:0]            dn_data2,
  output logic                     dn_valid,
  input  logic                     dn_ready,
  output logic                     start_out,
  output logic                     stop_out,
  output logic [$clog2(IMG_W)-1:0] col,
  output logic [$clog2(IMG_H)-1:0] row,
`ifdef OUT_STREAM_CTRL_EOL_EN
  output logic                     dn_eol,
  output logic                     dn_eof,
`endif
  output logic                     busy
);

  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int TOTAL = IMG_W * IMG_H;
  localparam int NW    = $clog2(TOTAL + 1);
`ifdef OUT_STREAM_CTRL_EOL_EN
  localparam int FW    = 3 * DW + 2;
`else
  localparam int FW    = 3 * DW;
`endif

  osc_state_t    r_state;
  osc_state_t    w_state_next;
  logic [NW-1:0] r_in_cnt;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          w_run;
  logic          w_fifo_s_tready;
  logic          w_up_push;
  logic          w_dn_pop;
  logic          w_last_in;
  logic          w_last_out;
  logic          w_frame_go;
  logic [FW-1:0] w_wdata;
  logic [FW-1:0] w_rdata;
`ifdef OUT_STREAM_CTRL_EOL_EN
  logic [CW-1:0] r_in_col;
`endif

  assign up_ready   = w_run && w_fifo_s_tready;
  assign w_up_push  = up_valid && up_ready;
  assign w_dn_pop   = dn_valid && dn_ready;
  assign w_last_in  = (r_in_cnt == NW'(TOTAL - 1));
  assign w_last_out = (r_col == CW'(IMG_W - 1)) && (r_row == RW'(IMG_H - 1));
  assign w_frame_go = go && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign col        = r_col;
  assign row        = r_row;

`ifdef OUT_STREAM_CTRL_EOL_EN
  assign w_wdata = {w_last_in, (r_in_col == CW'(IMG_W - 1)), up_data2, up_data1, up_data0};
  assign dn_eol  = w_rdata[3*DW];
  assign dn_eof  = w_rdata[3*DW+1];
`else
  assign w_wdata = {up_data2, up_data1, up_data0};
`endif
  assign {dn_data2, dn_data1, dn_data0} = w_rdata[3*DW-1:0];

  osc_skid_fifo #(
    .W (FW)
  ) u_skid (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_s_tvalid (up_valid && w_run),
    .i_s_tdata  (w_wdata),
    .o_s_tready (w_fifo_s_tready),
    .o_m_tvalid (dn_valid),
    .o_m_tdata  (w_rdata),
    .i_m_tready (dn_ready)
  );

  // Frame sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and per-state outputs; go only matters in IDLE and DONE.
  always_comb begin
    w_state_next = r_state;
    start_out    = 1'b0;
    stop_out     = 1'b0;
    busy         = 1'b0;
    w_run        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (go) w_state_next = S_START;
      end
      S_START: begin
        start_out    = 1'b1;
        busy         = 1'b1;
        w_state_next = S_RUN;
      end
      S_RUN: begin
        busy  = 1'b1;
        w_run = 1'b1;
        if (w_up_push && w_last_in) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_dn_pop && w_last_out) w_state_next = S_DONE;
      end
      S_DONE: begin
        stop_out = 1'b1;
        if (go) w_state_next = S_START;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Input beat count and output raster position, cleared as a frame starts.
  always_ff @(posedge clk) begin
    if (reset || w_frame_go) begin
      r_in_cnt <= '0;
      r_col    <= '0;
      r_row    <= '0;
`ifdef OUT_STREAM_CTRL_EOL_EN
      r_in_col <= '0;
`endif
    end else begin
      if (w_up_push) begin
        r_in_cnt <= r_in_cnt + NW'(1);
`ifdef OUT_STREAM_CTRL_EOL_EN
        r_in_col <= (r_in_col == CW'(IMG_W - 1)) ? '0 : r_in_col + CW'(1);
`endif
      end
      if (w_dn_pop) begin
        if (r_col == CW'(IMG_W - 1)) begin
          r_col <= '0;
          r_row <= (r_row == RW'(IMG_H - 1)) ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_out_stream_ctrl.sv
// tb/tb_out_stream_ctrl.sv - self-checking bench for out_stream_ctrl (optionally OUT_STREAM_CTRL_EOL_EN)
module tb_out_stream_ctrl;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int DW    = 8;
  localparam int TOTAL = W * H;

  logic          clk = 1'b0;
  logic          reset;
  logic          go;
  logic [DW-1:0] up_data0, up_data1, up_data2;
  logic          up_valid;
  logic          up_ready;
  logic [DW-1:0] dn_data0, dn_data1, dn_data2;
  logic          dn_valid;
  logic          dn_ready;
  logic          start_out;
  logic          stop_out;
  logic [1:0]    col;
  logic [0:0]    row;
  logic          busy;
`ifdef OUT_STREAM_CTRL_EOL_EN
  logic          dn_eol;
  logic          dn_eof;
`endif

  always #5 clk = ~clk;

  out_stream_ctrl #(
    .IMG_W (W),
    .IMG_H (H),
    .DW    (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .up_data0  (up_data0),
    .up_data1  (up_data1),
    .up_data2  (up_data2),
    .up_valid  (up_valid),
    .up_ready  (up_ready),
    .dn_data0  (dn_data0),
    .dn_data1  (dn_data1),
    .dn_data2  (dn_data2),
    .dn_valid  (dn_valid),
    .dn_ready  (dn_ready),
    .start_out (start_out),
    .stop_out  (stop_out),
    .col       (col),
    .row       (row),
`ifdef OUT_STREAM_CTRL_EOL_EN
    .dn_eol    (dn_eol),
    .dn_eof    (dn_eof),
`endif
    .busy      (busy)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [23:0] model_q [$];
  logic [23:0] cur_data;
  int          in_idx, out_idx;
  bit          m_start, m_active, m_done;
  bit          hold_v;
  logic [23:0] hold_d;
  int          uv_mode, dr_mode, stall_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    model_q.delete();
    in_idx   = 0;
    out_idx  = 0;
    m_start  = 0;
    m_active = 0;
    m_done   = 0;
    hold_v   = 0;
  endtask

  // One clock: drive inputs at the falling edge, compare, then advance the model.
  task automatic tick();
    logic [23:0] dn_word;
    logic [23:0] exp_word;
    bit          exp_up_ready, exp_dn_valid, push, pop, start_now;
    up_valid = (uv_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    {up_data2, up_data1, up_data0} = cur_data;
    if (dr_mode == 0) begin
      dn_ready = 1'b1;
    end else if (dr_mode == 2) begin
      dn_ready = 1'b0;
    end else if (stall_cnt > 0) begin
      dn_ready = 1'b0;
      stall_cnt--;
    end else if ($urandom_range(0, 1) == 1) begin
      dn_ready  = 1'b0;
      stall_cnt = $urandom_range(1, 32) - 1;
    end else begin
      dn_ready = 1'b1;
    end
    #1;
    dn_word      = {dn_data2, dn_data1, dn_data0};
    exp_up_ready = m_active && (in_idx < TOTAL) && (model_q.size() < 2);
    exp_dn_valid = (model_q.size() > 0);
    chk("up_ready", 32'(up_ready), 32'(exp_up_ready));
    chk("dn_valid", 32'(dn_valid), 32'(exp_dn_valid));
    chk("start_out", 32'(start_out), 32'(m_start));
    chk("stop_out", 32'(stop_out), 32'(m_done));
    chk("busy", 32'(busy), 32'(m_start || m_active));
    if (m_start) begin
      chk("start_col", 32'(col), 0);
      chk("start_row", 32'(row), 0);
    end
    if (hold_v) chk("dn_hold", 32'(dn_word), 32'(hold_d));
    if (reset) begin
      model_clear();
    end else begin
      push   = up_valid && exp_up_ready;
      pop    = exp_dn_valid && dn_ready;
      hold_v = exp_dn_valid && !dn_ready;
      hold_d = dn_word;
      if (pop) begin
        exp_word = model_q.pop_front();
        chk("dn_data", 32'(dn_word), 32'(exp_word));
        chk("col", 32'(col), 32'(out_idx % W));
        chk("row", 32'(row), 32'(out_idx / W));
`ifdef OUT_STREAM_CTRL_EOL_EN
        chk("dn_eol", 32'(dn_eol), 32'((out_idx % W) == W - 1));
        chk("dn_eof", 32'(dn_eof), 32'(out_idx == TOTAL - 1));
`endif
        out_idx++;
      end
      if (push) begin
        model_q.push_back(cur_data);
        in_idx++;
        cur_data = 24'($urandom);
      end
      start_now = go && !m_start && !m_active;
      if (m_start) begin
        m_start  = 0;
        m_active = 1;
      end else if (m_active && pop && out_idx == TOTAL) begin
        m_active = 0;
        m_done   = 1;
      end
      if (start_now) begin
        m_start = 1;
        m_done  = 0;
        in_idx  = 0;
        out_idx = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic finish_frame(input int budget);
    for (int i = 0; i < budget && !m_done; i++) tick();
    chk("frame_done_stop", 32'(stop_out), 1);
  endtask

  task automatic run_frame(input int budget);
    go = 1'b1;
    tick();
    go = 1'b0;
    finish_frame(budget);
  endtask

  initial begin
    reset     = 1'b1;
    go        = 1'b0;
    up_valid  = 1'b0;
    dn_ready  = 1'b0;
    {up_data2, up_data1, up_data0} = '0;
    uv_mode   = 0;
    dr_mode   = 0;
    stall_cnt = 0;
    cur_data  = 24'($urandom);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("reset_col", 32'(col), 0);
    chk("reset_row", 32'(row), 0);

    // Basic 4x2 frame, always-valid source and always-ready sink.
    run_frame(60);

    // Sink stalled: exactly two beats absorbed, then backpressure and held data.
    dr_mode = 2;
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (6) tick();
    chk("stalled_up_ready", 32'(up_ready), 0);
    chk("stalled_fill_valid", 32'(dn_valid), 1);
    dr_mode = 0;
    finish_frame(60);

    // go held through START and RUN is ignored; go in DONE starts another frame.
    go = 1'b1;
    repeat (4) tick();
    go = 1'b0;
    finish_frame(60);
    run_frame(60);

    // Reset after the third output beat, then a clean restart.
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 40 && out_idx < 3; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_reset_dn_valid", 32'(dn_valid), 0);
    chk("mid_reset_up_ready", 32'(up_ready), 0);
    chk("mid_reset_busy", 32'(busy), 0);
    chk("mid_reset_stop", 32'(stop_out), 0);
    chk("mid_reset_start", 32'(start_out), 0);
    chk("mid_reset_col", 32'(col), 0);
    chk("mid_reset_row", 32'(row), 0);
    @(negedge clk);
    repeat (3) tick();
    chk("no_autostart_busy", 32'(busy), 0);
    run_frame(60);

    // Randomised source gaps and sink stalls of 1..32 cycles.
    uv_mode = 1;
    dr_mode = 1;
    for (int f = 0; f < 20; f++) run_frame(2000);
    uv_mode = 0;
    for (int f = 0; f < 10; f++) run_frame(2000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
